// File: rtl/scanline_scheduler.sv
// Per-scanline render sequencer: launches the tile pass and then the sprite pass for the next
// display line, flips the line-buffer select once both are done, and flags missed swap deadlines.
module scanline_scheduler #(
    parameter int HTOTAL  = 1600,
    parameter int VACTIVE = 480,
    parameter int VTOTAL  = 525,
    parameter int START_H = 0,
    parameter int SWAP_H  = 1590,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [10:0]      hcount,
    input  logic [9:0]       vcount,
    input  logic             tile_done,
    input  logic             sprite_done,
    output logic             tile_start,
    output logic             sprite_start,
    output logic [9:0]       draw_line,
    output logic             buf_sel,
    output logic             line_ready,
    output logic             frame_start,
    output logic             overrun,
    output logic [CNT_W-1:0] overrun_count,
    output logic             busy
);

    // A swap point past the end of the line could never match, so pin it to the last clock.
    localparam int               SWAP_CLAMP = (SWAP_H < HTOTAL) ? SWAP_H : HTOTAL - 1;
    localparam logic [10:0]      START_HC   = 11'(START_H);
    localparam logic [10:0]      SWAP_HC    = 11'(SWAP_CLAMP);
    localparam logic [9:0]       PREP_LIMIT = 10'(VACTIVE - 1);
    localparam logic [9:0]       LAST_V     = 10'(VTOTAL - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        T_GO,
        T_GUARD,
        T_WAIT,
        S_GO,
        S_GUARD,
        S_WAIT,
        READY
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [9:0] line_next;
    logic [9:0] target;
    logic       at_start;
    logic       at_swap;
    logic       prep;
    logic       launch_ok;
    logic       swap_now;
    logic       miss_now;

    always_comb begin
        at_start   = (hcount == START_HC);
        at_swap    = (hcount == SWAP_HC);
        prep       = (vcount < PREP_LIMIT) || (vcount == LAST_V);
        target     = (vcount == LAST_V) ? 10'd0 : vcount + 10'd1;
        launch_ok  = at_start && prep && enable;
        state_next = state;
        line_next  = draw_line;
        swap_now   = 1'b0;
        miss_now   = 1'b0;

        case (state)
            IDLE: begin
                if (launch_ok) begin
                    state_next = T_GO;
                    line_next  = target;
                end
            end
            T_GO:    state_next = T_GUARD;
            T_GUARD: state_next = T_WAIT;
            T_WAIT:  if (tile_done) state_next = S_GO;
            S_GO:    state_next = S_GUARD;
            S_GUARD: state_next = S_WAIT;
            S_WAIT:  if (sprite_done) state_next = READY;
            READY: begin
                // A line still unswapped at the next launch point is stale and gets replaced.
                if (at_swap) begin
                    swap_now   = 1'b1;
                    state_next = IDLE;
                end else if (at_start) begin
                    if (launch_ok) begin
                        state_next = T_GO;
                        line_next  = target;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (at_swap && (state != IDLE) && (state != READY)) begin
            miss_now = 1'b1;
        end
    end

    // Outputs are decoded from the next state so every pulse leaves a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            draw_line     <= '0;
            tile_start    <= 1'b0;
            sprite_start  <= 1'b0;
            frame_start   <= 1'b0;
            line_ready    <= 1'b0;
            overrun       <= 1'b0;
            busy          <= 1'b0;
            buf_sel       <= 1'b0;
            overrun_count <= '0;
        end else begin
            state        <= state_next;
            draw_line    <= line_next;
            tile_start   <= (state_next == T_GO);
            sprite_start <= (state_next == S_GO);
            frame_start  <= (state_next == T_GO) && (line_next == 10'd0);
            line_ready   <= swap_now;
            overrun      <= miss_now;
            busy         <= (state_next != IDLE);
            if (swap_now) begin
                buf_sel <= ~buf_sel;
            end
            if (miss_now && (overrun_count != CNT_MAX)) begin
                overrun_count <= overrun_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_scanline_scheduler.sv
// Directed bench for scanline_scheduler: per-line vector table plus hand sequences for
// stale-line discard, done guard, enable drop, reset abort and counter saturation.
module tb_scanline_scheduler;

    localparam int HTOTAL = 1600;
    localparam int VTOTAL = 525;
    localparam int SWAP_H = 1590;
    localparam int CNT_W  = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic [10:0]      hcount;
    logic [9:0]       vcount;
    logic             tile_done;
    logic             sprite_done;
    logic             tile_start;
    logic             sprite_start;
    logic [9:0]       draw_line;
    logic             buf_sel;
    logic             line_ready;
    logic             frame_start;
    logic             overrun;
    logic [CNT_W-1:0] overrun_count;
    logic             busy;

    scanline_scheduler #(
        .HTOTAL (HTOTAL),
        .VACTIVE(480),
        .VTOTAL (VTOTAL),
        .START_H(0),
        .SWAP_H (SWAP_H),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .hcount       (hcount),
        .vcount       (vcount),
        .tile_done    (tile_done),
        .sprite_done  (sprite_done),
        .tile_start   (tile_start),
        .sprite_start (sprite_start),
        .draw_line    (draw_line),
        .buf_sel      (buf_sel),
        .line_ready   (line_ready),
        .frame_start  (frame_start),
        .overrun      (overrun),
        .overrun_count(overrun_count),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Positions are the hcount visible after the edge on which a pulse appears; -1 means never.
    typedef struct {
        int v;
        bit en;
        int td;
        int sd;
        int tile_h;
        int sprite_h;
        int ready_h;
        int ovr_h;
        int line;
        int frame_h;
    } vec_t;

    vec_t vecs[11];
    int   n_vec = 0;
    int   n_miss = 0;
    int   tile_delay, sprite_delay, tile_cnt, sprite_cnt;
    bit   tile_stuck_hi;
    int   obs_tile_h, obs_sprite_h, obs_ready_h, obs_ovr_h, obs_frame_h;
    int   n_tile, n_sprite, n_ready, n_ovr;

    task automatic checkOutput(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clearObs();
        obs_tile_h   = -1;
        obs_sprite_h = -1;
        obs_ready_h  = -1;
        obs_ovr_h    = -1;
        obs_frame_h  = -1;
        n_tile       = 0;
        n_sprite     = 0;
        n_ready      = 0;
        n_ovr        = 0;
    endtask

    // One clock: advance the beam, log output pulses, then update the engine models.
    task automatic stepClock();
        @(posedge clk);
        #1;
        if (hcount == 11'(HTOTAL - 1)) begin
            hcount = 11'd0;
            vcount = (vcount == 10'(VTOTAL - 1)) ? 10'd0 : vcount + 10'd1;
        end else begin
            hcount = hcount + 11'd1;
        end
        if (tile_start) begin
            n_tile++;
            if (obs_tile_h < 0) obs_tile_h = int'(hcount);
        end
        if (sprite_start) begin
            n_sprite++;
            if (obs_sprite_h < 0) obs_sprite_h = int'(hcount);
        end
        if (line_ready) begin
            n_ready++;
            if (obs_ready_h < 0) obs_ready_h = int'(hcount);
        end
        if (overrun) begin
            n_ovr++;
            if (obs_ovr_h < 0) obs_ovr_h = int'(hcount);
        end
        if (frame_start && obs_frame_h < 0) obs_frame_h = int'(hcount);

        if (reset) begin
            tile_done   = 1'b1;
            sprite_done = 1'b1;
            tile_cnt    = 0;
            sprite_cnt  = 0;
        end else begin
            if (tile_start) begin
                tile_cnt  = tile_delay;
                tile_done = tile_stuck_hi;
            end else if (tile_cnt > 0) begin
                tile_cnt--;
                if (tile_cnt == 0) tile_done = 1'b1;
            end
            if (sprite_start) begin
                sprite_cnt  = sprite_delay;
                sprite_done = 1'b0;
            end else if (sprite_cnt > 0) begin
                sprite_cnt--;
                if (sprite_cnt == 0) sprite_done = 1'b1;
            end
        end
    endtask

    task automatic runSteps(input int n);
        for (int k = 0; k < n; k++) stepClock();
    endtask

    task automatic startLine(input int v, input bit en, input int td, input int sd);
        reset        = 1'b1;
        enable       = en;
        tile_delay   = td;
        sprite_delay = sd;
        stepClock();
        reset  = 1'b0;
        hcount = 11'd0;
        vcount = 10'(v);
        clearObs();
    endtask

    task automatic applyStimulus(input vec_t vec);
        startLine(vec.v, vec.en, vec.td, vec.sd);
        runSteps(HTOTAL);
    endtask

    initial begin
        vecs[0]  = '{10,  1'b1, 20, 20,   1,  22, 1591,   -1,  11, -1};
        vecs[1]  = '{524, 1'b1, 20, 20,   1,  22, 1591,   -1,   0,  1};
        vecs[2]  = '{479, 1'b1, 20, 20,  -1,  -1,   -1,   -1,   0, -1};
        vecs[3]  = '{500, 1'b1, 20, 20,  -1,  -1,   -1,   -1,   0, -1};
        vecs[4]  = '{523, 1'b1, 20, 20,  -1,  -1,   -1,   -1,   0, -1};
        vecs[5]  = '{478, 1'b1, 20, 20,   1,  22, 1591,   -1, 479, -1};
        vecs[6]  = '{10,  1'b0, 20, 20,  -1,  -1,   -1,   -1,   0, -1};
        vecs[7]  = '{0,   1'b1,  5, 100,  1,   7, 1591,   -1,   1, -1};
        vecs[8]  = '{20,  1'b1, 20, 1573, 1,  22,   -1, 1591,  21, -1};
        vecs[9]  = '{30,  1'b1, 20, 1567, 1,  22, 1591,   -1,  31, -1};
        vecs[10] = '{30,  1'b1, 20, 1568, 1,  22,   -1, 1591,  31, -1};

        reset         = 1'b1;
        enable        = 1'b0;
        hcount        = 11'd0;
        vcount        = 10'd0;
        tile_done     = 1'b1;
        sprite_done   = 1'b1;
        tile_delay    = 20;
        sprite_delay  = 20;
        tile_cnt      = 0;
        sprite_cnt    = 0;
        tile_stuck_hi = 1'b0;
        clearObs();
        runSteps(2);
        checkOutput("reset pulses", int'({tile_start, sprite_start, line_ready, frame_start, overrun}), 0);
        checkOutput("reset buf_sel", int'(buf_sel), 0);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset draw_line", int'(draw_line), 0);
        checkOutput("reset overrun_count", int'(overrun_count), 0);

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d tile_h", i), obs_tile_h, vecs[i].tile_h);
            checkOutput($sformatf("vec%0d sprite_h", i), obs_sprite_h, vecs[i].sprite_h);
            checkOutput($sformatf("vec%0d ready_h", i), obs_ready_h, vecs[i].ready_h);
            checkOutput($sformatf("vec%0d overrun_h", i), obs_ovr_h, vecs[i].ovr_h);
            checkOutput($sformatf("vec%0d frame_h", i), obs_frame_h, vecs[i].frame_h);
            checkOutput($sformatf("vec%0d draw_line", i), int'(draw_line), vecs[i].line);
            checkOutput($sformatf("vec%0d tile pulses", i), n_tile, (vecs[i].tile_h >= 0) ? 1 : 0);
            checkOutput($sformatf("vec%0d ready pulses", i), n_ready, (vecs[i].ready_h >= 0) ? 1 : 0);
            checkOutput($sformatf("vec%0d overrun_count", i), int'(overrun_count), (vecs[i].ovr_h >= 0) ? 1 : 0);
            checkOutput($sformatf("vec%0d buf_sel", i), int'(buf_sel), (vecs[i].ready_h >= 0) ? 1 : 0);
            checkOutput($sformatf("vec%0d busy", i), int'(busy),
                        (vecs[i].tile_h >= 0 && vecs[i].ready_h < 0) ? 1 : 0);
        end

        // Late sprite pass: overrun at the deadline, then the stale line is replaced at START_H.
        startLine(10, 1'b1, 20, 1573);
        runSteps(HTOTAL + 1);
        checkOutput("stale overrun_h", obs_ovr_h, 1591);
        checkOutput("stale overrun pulses", n_ovr, 1);
        checkOutput("stale overrun_count", int'(overrun_count), 1);
        checkOutput("stale ready pulses", n_ready, 0);
        checkOutput("stale buf_sel", int'(buf_sel), 0);
        checkOutput("stale tile pulses", n_tile, 2);
        checkOutput("stale tile_start now", int'(tile_start), 1);
        checkOutput("stale draw_line", int'(draw_line), 12);

        // Tile engine reports done all the time; the guard cycle must hold off the sprite pass.
        tile_stuck_hi = 1'b1;
        startLine(10, 1'b1, 20, 20);
        runSteps(10);
        tile_stuck_hi = 1'b0;
        checkOutput("guard tile_h", obs_tile_h, 1);
        checkOutput("guard sprite_h", obs_sprite_h, 4);
        checkOutput("guard sprite pulses", n_sprite, 1);

        // Enable dropped while waiting on the tile engine: pass finishes, next line stays idle.
        startLine(10, 1'b1, 20, 20);
        runSteps(9);
        enable = 1'b0;
        runSteps(HTOTAL - 9 + 5);
        checkOutput("endrop ready_h", obs_ready_h, 1591);
        checkOutput("endrop buf_sel", int'(buf_sel), 1);
        checkOutput("endrop tile pulses", n_tile, 1);
        checkOutput("endrop sprite pulses", n_sprite, 1);
        checkOutput("endrop busy", int'(busy), 0);

        // Reset while the sprite pass is running aborts everything, including buf_sel.
        enable = 1'b1;
        hcount = 11'd0;
        vcount = 10'd12;
        clearObs();
        runSteps(30);
        checkOutput("rstmid busy before", int'(busy), 1);
        checkOutput("rstmid buf_sel before", int'(buf_sel), 1);
        checkOutput("rstmid draw_line before", int'(draw_line), 13);
        reset = 1'b1;
        stepClock();
        reset = 1'b0;
        checkOutput("rstmid busy", int'(busy), 0);
        checkOutput("rstmid buf_sel", int'(buf_sel), 0);
        checkOutput("rstmid draw_line", int'(draw_line), 0);
        checkOutput("rstmid pulses", int'({tile_start, sprite_start, line_ready, frame_start, overrun}), 0);

        // Hung tile engine: one overrun per swap point, counter pinned at its maximum.
        startLine(100, 1'b1, -1, 20);
        runSteps(5);
        for (int k = 1; k <= 19; k++) begin
            hcount = 11'(SWAP_H - 1);
            runSteps(3);
            checkOutput($sformatf("sat overrun_count #%0d", k), int'(overrun_count), (k < 15) ? k : 15);
        end
        checkOutput("sat overrun pulses", n_ovr, 19);
        checkOutput("sat ready pulses", n_ready, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/scanline_scheduler.md
Name: scanline_scheduler

Overview:
Per-scanline sequencer for the double-buffered line renderer. It tracks the VGA beam position, launches the tile engine and then the sprite engine for the next display line, and waits on their done handshakes. It flips the line-buffer display/draw select once the line is complete and reports missed deadlines. It sits between vga_counters and the tile engine, the sprite engine and the linebuffer, replacing the ad-hoc start/switch logic in the top level.

Parameters:
HTOTAL, 1600, clocks per line (hcount wraps at HTOTAL-1)
VACTIVE, 480, visible lines
VTOTAL, 525, lines per frame
START_H, 0, hcount at which the tile pass is launched
SWAP_H, 1590, hcount at which the buffer flip is evaluated; must satisfy START_H < SWAP_H < HTOTAL
CNT_W, 16, overrun counter width

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  synchronous, active-high reset
enable  in  1  ctrl bit; 0 = launch no new passes
hcount  in  11  beam horizontal count from vga_counters
vcount  in  10  beam line count from vga_counters
tile_done  in  1  tile engine idle/finished (level)
sprite_done  in  1  sprite engine idle/finished (level)
tile_start  out  1  one-cycle launch pulse to tile engine
sprite_start  out  1  one-cycle launch pulse to sprite engine
draw_line  out  10  line number being rendered, latched at launch
buf_sel  out  1  linebuffer switch; toggles once per completed line
line_ready  out  1  one-cycle pulse coincident with a buf_sel toggle
frame_start  out  1  one-cycle pulse when the line-0 pass launches
overrun  out  1  one-cycle pulse on a missed swap deadline
overrun_count  out  CNT_W  saturating count of overruns; cleared only by reset
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: state IDLE; all outputs 0; draw_line = 0; overrun_count = 0. Reset mid-pass aborts the pass immediately; the engines are reset by the same signal.
- Prep line: vcount < VACTIVE-1 (renders vcount+1) or vcount == VTOTAL-1 (renders 0). target = (vcount == VTOTAL-1) ? 0 : vcount+1.
- States: IDLE, T_GO, T_GUARD, T_WAIT, S_GO, S_GUARD, S_WAIT, READY.
- IDLE -> T_GO when hcount == START_H, prep line and enable. draw_line <= target on the same edge.
- T_GO: tile_start = 1 for exactly this cycle; frame_start = 1 if draw_line == 0. Next state T_GUARD.
- T_GUARD: one cycle during which tile_done is ignored (the engine drops done within 1 cycle of start). Next state T_WAIT.
- T_WAIT -> S_GO when tile_done == 1.
- S_GO: sprite_start = 1 for one cycle -> S_GUARD (one cycle, done ignored) -> S_WAIT.
- S_WAIT -> READY when sprite_done == 1.
- READY: at hcount == SWAP_H: buf_sel toggles, line_ready = 1, next state IDLE.
- Deadline miss: at hcount == SWAP_H with state not in {READY, IDLE}: no toggle, overrun = 1, overrun_count += 1 (holds at all-ones). The pass continues to completion.
- Stale READY: at hcount == START_H with state READY, the stale line is discarded and the FSM goes straight to T_GO (if prep line and enable, latching a new draw_line); otherwise it goes to IDLE. No toggle occurs.
- At hcount == START_H with state in T_*/S_* (engine still running): no launch this line and no extra overrun count.
- enable low: blocks only the IDLE->T_GO and READY->T_GO launches. An in-flight pass still completes and still swaps.
- Non-prep lines (vcount 479..523): no launches; a READY state may still swap at SWAP_H.
- Launch-to-start latency is 1 clock (tile_start is asserted at hcount == START_H+1). A tile-to-sprite handoff takes 1 clock after tile_done is sampled.
- All outputs are registered; pulses are exactly 1 cycle wide.

Test Plan:
- Nominal: enable=1, vcount=10, engines assert done 20 clocks after start. Expect tile_start at hcount 1, sprite_start about 22 clocks later, draw_line=11, buf_sel toggles and line_ready pulses at hcount 1591, overrun_count stays 0.
- Frame wrap: vcount=524, hcount=0. Expect draw_line=0 with frame_start and tile_start on the same cycle. At vcount=479..523, no start pulses over a full line.
- Overrun: sprite_done held low until hcount 1595. Expect overrun pulse at 1591, no buf_sel toggle, overrun_count=1. At the next START_H, the stale READY is discarded and a new tile_start is issued with draw_line incremented.
- Guard: tile_done held 1 throughout (stale). Expect sprite_start no earlier than 3 clocks after tile_start, never in the same or the next cycle.
- Enable/reset: drop enable mid-T_WAIT. Expect the pass to finish and swap, with no tile_start on the following line. Assert reset during S_WAIT: next cycle state is IDLE, buf_sel=0, busy=0.
- Saturation: force 2^CNT_W+3 consecutive overruns (shortened CNT_W=4 build). Expect overrun_count to hold at 15.
